// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator: Horner accumulation of S_i = r(alpha^(FCR+i)), i=0..15.
// Optional RS_SYN_ZERO_FLAG_EN adds the registered syn_zero output (all syndromes zero).
module rs_syndrome_calc #(
    parameter int unsigned N         = 255,
    parameter int unsigned FCR       = 1,
    parameter logic [8:0]  PRIM_POLY = 9'h11D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic [7:0] s0,
    output logic [7:0] s1,
    output logic [7:0] s2,
    output logic [7:0] s3,
    output logic [7:0] s4,
    output logic [7:0] s5,
    output logic [7:0] s6,
    output logic [7:0] s7,
    output logic [7:0] s8,
    output logic [7:0] s9,
    output logic [7:0] s10,
    output logic [7:0] s11,
    output logic [7:0] s12,
    output logic [7:0] s13,
    output logic [7:0] s14,
    output logic [7:0] s15,
`ifdef RS_SYN_ZERO_FLAG_EN
    output logic       syn_zero,
`endif
    output logic       S_ready
);

    localparam int unsigned SYM_W = 8;
    localparam int unsigned NSYN  = 16;
    localparam int unsigned CNT_W = $clog2(N);

    typedef enum logic {IDLE, ACC} state_t;

    // Multiply by alpha (x) modulo the field polynomial.
    function automatic logic [SYM_W-1:0] xtime(input logic [SYM_W-1:0] a);
        return {a[SYM_W-2:0], 1'b0} ^ (a[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : SYM_W'(0));
    endfunction

    // Shift-and-add product; with a constant b this reduces to an XOR network.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < int'(SYM_W); k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [SYM_W-1:0] gf_pow(input int unsigned e);
        logic [SYM_W-1:0] p;
        p = SYM_W'(1);
        for (int unsigned k = 0; k < e; k++) p = xtime(p);
        return p;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] acc_q [NSYN];
    logic [SYM_W-1:0] acc_d [NSYN];
    logic [SYM_W-1:0] acc_mul [NSYN];
    logic [SYM_W-1:0] s_q [NSYN];
    logic [SYM_W-1:0] s_d [NSYN];
    logic             s_ready_q, s_ready_d;
    logic             busy_q, busy_d;

    for (genvar g = 0; g < int'(NSYN); g++) begin : g_root
        localparam logic [SYM_W-1:0] ROOT = gf_pow(FCR + g);
        assign acc_mul[g] = gf_mul(acc_q[g], ROOT);
    end

    // Next-state, accumulator and syndrome capture logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        s_d       = s_q;
        s_ready_d = 1'b0;
        if (in_valid && in_sof) begin
            for (int i = 0; i < int'(NSYN); i++) acc_d[i] = in_data;
            cnt_d   = CNT_W'(1);
            state_d = ACC;
        end else if (in_valid && (state_q == ACC)) begin
            for (int i = 0; i < int'(NSYN); i++) acc_d[i] = acc_mul[i] ^ in_data;
            if (cnt_q == CNT_W'(N - 1)) begin
                s_d       = acc_d;
                s_ready_d = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        busy_d = (state_d == ACC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < int'(NSYN); i++) begin
                acc_q[i] <= '0;
                s_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            acc_q     <= acc_d;
            s_q       <= s_d;
        end
    end

`ifdef RS_SYN_ZERO_FLAG_EN
    logic zero_q, zero_d;

    // Error-free flag, captured on the same edge as the syndromes.
    always_comb begin
        zero_d = zero_q;
        if (s_ready_d) begin
            zero_d = 1'b1;
            for (int i = 0; i < int'(NSYN); i++) begin
                if (s_d[i] != '0) zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) zero_q <= 1'b0;
        else        zero_q <= zero_d;
    end

    assign syn_zero = zero_q;
`endif

    assign busy    = busy_q;
    assign S_ready = s_ready_q;
    assign s0  = s_q[0];
    assign s1  = s_q[1];
    assign s2  = s_q[2];
    assign s3  = s_q[3];
    assign s4  = s_q[4];
    assign s5  = s_q[5];
    assign s6  = s_q[6];
    assign s7  = s_q[7];
    assign s8  = s_q[8];
    assign s9  = s_q[9];
    assign s10 = s_q[10];
    assign s11 = s_q[11];
    assign s12 = s_q[12];
    assign s13 = s_q[13];
    assign s14 = s_q[14];
    assign s15 = s_q[15];

endmodule
